// File: rtl/pp_pipeline_accel_mul_arbiter.sv
// pp_pipeline_accel_mul_arbiter: round-robin sharing of one pipelined 12u x 9s multiplier
// Ports:
//   ap_clk, ap_rst_n                      clock, asynchronous active-low reset
//   req_valid, req_ready, req_a, req_b    per-requester operand handshake, slice i = requester i
//   mul_ce, mul_din0, mul_din1, mul_dout  external ce-gated multiplier, MUL_LAT cycles din->dout
//   rsp_valid, rsp_ready, rsp_id, rsp_data  product stream tagged with the issuing requester
//   inflight, busy                        occupancy of the shadow pipe, activity flag
module pp_pipeline_accel_mul_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int MUL_LAT = 3
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*12-1:0] req_a,
    input  logic [NUM_REQ*9-1:0]  req_b,
    output logic                  mul_ce,
    output logic [11:0]           mul_din0,
    output logic [8:0]            mul_din1,
    input  logic [20:0]           mul_dout,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [20:0]           rsp_data,
    output logic [1:0]            inflight,
    output logic                  busy
);
    logic [ID_W-1:0]    ptr;
    logic [ID_W-1:0]    grant_idx;
    logic [ID_W-1:0]    cand;
    logic [ID_W:0]      sum;
    logic               found;
    logic               adv;
    logic               xfer;
    logic [MUL_LAT-1:0] vld;
    logic [ID_W-1:0]    ids [MUL_LAT];

    // A held response freezes both the multiplier and the shadow pipe in lockstep.
    assign adv    = !(rsp_valid && !rsp_ready);
    assign mul_ce = adv;

    // Scan offsets from high to low so the requester closest to ptr is assigned last and wins.
    always_comb begin
        grant_idx = '0;
        found     = 1'b0;
        sum       = '0;
        cand      = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            sum  = {1'b0, ptr} + (ID_W+1)'(k);
            cand = (sum >= (ID_W+1)'(NUM_REQ)) ? ID_W'(sum - (ID_W+1)'(NUM_REQ)) : sum[ID_W-1:0];
            if (req_valid[cand]) begin
                found     = 1'b1;
                grant_idx = cand;
            end
        end
    end

    assign xfer      = adv && found;
    assign req_ready = xfer ? (NUM_REQ'(1) << grant_idx) : '0;
    assign mul_din0  = xfer ? req_a[grant_idx*12 +: 12] : '0;
    assign mul_din1  = xfer ? req_b[grant_idx*9 +: 9] : '0;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            ptr      <= '0;
            vld      <= '0;
            inflight <= '0;
        end else if (adv) begin
            vld      <= {vld[MUL_LAT-2:0], xfer};
            inflight <= inflight + 2'(xfer) - 2'(rsp_valid && rsp_ready);
            if (xfer)
                ptr <= (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    // Ids need no reset: a stale id is always masked by its vld bit.
    always_ff @(posedge ap_clk) begin
        if (adv) begin
            ids[0] <= grant_idx;
            for (int k = 1; k < MUL_LAT; k++)
                ids[k] <= ids[k-1];
        end
    end

    assign rsp_valid = vld[MUL_LAT-1];
    assign rsp_id    = ids[MUL_LAT-1];
    assign rsp_data  = mul_dout;
    assign busy      = |req_valid || inflight != 2'd0;
endmodule

// File: tb/tb_pp_pipeline_accel_mul_arbiter.sv
// tb_pp_pipeline_accel_mul_arbiter: table, directed and random checks against a queue-based model
module tb_pp_pipeline_accel_mul_arbiter;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic            ap_clk = 1'b0;
    logic            ap_rst_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*12-1:0] req_a;
    logic [N*9-1:0]  req_b;
    logic            mul_ce;
    logic [11:0]     mul_din0;
    logic [8:0]      mul_din1;
    logic [20:0]     mul_dout;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [20:0]     rsp_data;
    logic [1:0]      inflight;
    logic            busy;

    pp_pipeline_accel_mul_arbiter #(.NUM_REQ(N), .ID_W(2), .MUL_LAT(LAT)) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .mul_ce(mul_ce), .mul_din0(mul_din0), .mul_din1(mul_din1), .mul_dout(mul_dout),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .inflight(inflight), .busy(busy)
    );

    always #5 ap_clk = ~ap_clk;

    // External multiplier: 3 ce-gated stages, no reset
    logic [20:0] mp [LAT];
    always_ff @(posedge ap_clk) begin
        if (mul_ce) begin
            mp[0] <= $signed({1'b0, mul_din0}) * $signed(mul_din1);
            mp[1] <= mp[0];
            mp[2] <= mp[1];
        end
    end
    assign mul_dout = mp[2];

    typedef struct { int id; logic [20:0] prod; int age; } op_t;
    typedef struct { logic [N-1:0] v; logic [N-1:0] rdy; } vec_t;

    op_t          q[$];
    vec_t         tbl[13];
    int           mptr;
    int           waits[N];
    int           checks;
    int           errors;
    int           consumed;
    logic [N-1:0] rv;
    logic [11:0]  ra[N];
    logic [8:0]   rb[N];
    logic         seen_rv;
    logic [1:0]   seen_id;
    logic [20:0]  seen_data;
    logic [N-1:0] seen_ready;
    logic [20:0]  held;

    function automatic logic [20:0] mprod(input logic [11:0] a, input logic [8:0] b);
        int bi, r;
        bi = b[8] ? int'(b) - 512 : int'(b);
        r  = int'(a) * bi;
        return r[20:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        mptr = 0;
        for (int i = 0; i < N; i++) waits[i] = 0;
    endtask

    // One clock cycle: drive at posedge+1, check at negedge, advance the model for the coming edge.
    task automatic step();
        int g;
        logic exp_rv, adv;
        logic [N-1:0] exp_rdy;
        logic [11:0] exp_a;
        logic [8:0] exp_b;
        req_valid = rv;
        for (int i = 0; i < N; i++) begin
            req_a[i*12 +: 12] = ra[i];
            req_b[i*9 +: 9]   = rb[i];
        end
        @(negedge ap_clk);
        exp_rv = q.size() > 0 && q[0].age >= LAT;
        adv = !(exp_rv && !rsp_ready);
        g = -1;
        if (adv)
            for (int k = 0; k < N; k++)
                if (g < 0 && rv[(mptr + k) % N]) g = (mptr + k) % N;
        exp_rdy = '0;
        exp_a = '0;
        exp_b = '0;
        if (g >= 0) begin
            exp_rdy = N'(1) << g;
            exp_a = ra[g];
            exp_b = rb[g];
        end
        seen_rv = rsp_valid;
        seen_id = rsp_id;
        seen_data = rsp_data;
        seen_ready = req_ready;
        chk("rsp_valid", rsp_valid, exp_rv);
        if (exp_rv) begin
            chk("rsp_id", rsp_id, q[0].id);
            chk("rsp_data", rsp_data, q[0].prod);
        end
        chk("mul_ce", mul_ce, adv);
        chk("req_ready", req_ready, exp_rdy);
        chk("mul_din0", mul_din0, exp_a);
        chk("mul_din1", mul_din1, exp_b);
        chk("inflight", inflight, q.size());
        chk("busy", busy, (rv != 0) || (q.size() != 0));
        if (req_ready != 0)
            for (int i = 0; i < N; i++)
                if (rv[i]) begin
                    if (req_ready[i]) begin
                        chk("starve", waits[i] <= N - 1, 1);
                        waits[i] = 0;
                    end else waits[i]++;
                end
        if (adv) begin
            if (exp_rv) begin
                void'(q.pop_front());
                consumed++;
            end
            foreach (q[k]) q[k].age++;
            if (g >= 0) begin
                q.push_back('{g, mprod(ra[g], rb[g]), 1});
                mptr = (g + 1) % N;
                rv[g] = 1'b0;
            end
        end
        @(posedge ap_clk);
        #1;
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_inflight", inflight, 0);
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        clear_model();
    endtask

    initial begin
        int cyc, c0;
        checks = 0;
        errors = 0;
        consumed = 0;
        rv = '0;
        rsp_ready = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0;
            rb[i] = '0;
        end
        clear_model();
        tbl[0]  = '{4'b0000, 4'b0000};
        tbl[1]  = '{4'b1111, 4'b0001};
        tbl[2]  = '{4'b1111, 4'b0010};
        tbl[3]  = '{4'b1010, 4'b1000};
        tbl[4]  = '{4'b1010, 4'b0010};
        tbl[5]  = '{4'b1010, 4'b1000};
        tbl[6]  = '{4'b0001, 4'b0001};
        tbl[7]  = '{4'b0001, 4'b0001};
        tbl[8]  = '{4'b0100, 4'b0100};
        tbl[9]  = '{4'b0011, 4'b0001};
        tbl[10] = '{4'b0000, 4'b0000};
        tbl[11] = '{4'b0101, 4'b0100};
        tbl[12] = '{4'b1001, 4'b1000};

        #2 ap_rst_n = 1'b0;
        repeat (2) @(posedge ap_clk);
        #1;
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_inflight", inflight, 0);
        chk("reset_busy", busy, 0);
        ap_rst_n = 1'b1;

        // Single op latency and value
        ra[0] = 12'hFFF;
        rb[0] = 9'h1FF;
        rv = 4'b0001;
        step();
        chk("t1_grant", seen_ready, 1);
        step();
        chk("t1_lat1", seen_rv, 0);
        step();
        chk("t1_lat2", seen_rv, 0);
        step();
        chk("t1_valid", seen_rv, 1);
        chk("t1_id", seen_id, 0);
        chk("t1_data", seen_data, 21'h1FF001);

        // Round-robin table from pointer 0
        do_reset();
        ra[0] = 12'hFFF; rb[0] = 9'h1FF;
        ra[1] = 12'd7;   rb[1] = 9'd9;
        ra[2] = 12'h800; rb[2] = 9'd255;
        ra[3] = 12'd100; rb[3] = 9'h180;
        for (int i = 0; i < 13; i++) begin
            rv = tbl[i].v;
            step();
            chk("tbl_ready", seen_ready, tbl[i].rdy);
        end

        // All requesters continuously valid
        for (int k = 0; k < 12; k++) begin
            rv = 4'b1111;
            step();
            chk("t2_grant", seen_ready, 1 << (k % 4));
        end
        rv = '0;
        repeat (4) step();

        // Stall with three in flight
        rsp_ready = 1'b0;
        repeat (3) begin
            rv = 4'b1111;
            step();
        end
        for (int k = 0; k < 5; k++) begin
            rv = 4'b1111;
            step();
            if (k == 0) held = seen_data;
            chk("t3_ce", mul_ce, 0);
            chk("t3_hold", seen_data, held);
            chk("t3_inflight", inflight, 3);
        end
        rsp_ready = 1'b1;
        rv = '0;
        repeat (6) step();

        // Reset mid-burst with three in flight
        rsp_ready = 1'b0;
        repeat (3) begin
            rv = 4'b1111;
            step();
        end
        chk("t5_pre_valid", rsp_valid, 1);
        do_reset();
        rsp_ready = 1'b1;
        rv = 4'b1111;
        step();
        chk("t5_first_grant", seen_ready, 1);
        repeat (6) begin
            rv = 4'b1111;
            step();
        end

        // Random soak
        c0 = consumed;
        cyc = 0;
        while (consumed < c0 + 10000 && cyc < 60000) begin
            for (int i = 0; i < N; i++)
                if (!rv[i] && $urandom_range(0, 99) < 60) begin
                    rv[i] = 1'b1;
                    ra[i] = 12'($urandom);
                    rb[i] = 9'($urandom);
                end
            rsp_ready = $urandom_range(0, 99) < 75;
            step();
            cyc++;
        end
        chk("soak_done", consumed >= c0 + 10000, 1);
        rv = '0;
        rsp_ready = 1'b1;
        repeat (5) step();
        chk("final_inflight", inflight, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
